// File: rtl/cov_arb_pkg.sv
// Shared types and widths for the convolution arbiter.
// State encoding and datapath operand sizes.
package cov_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam int PIX_W  = 10;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int RES_W  = 21;
  localparam int WIN_W  = PIX_W * TAPS;
  localparam int K_W    = COEF_W * TAPS;

endpackage

// File: rtl/cov_arb_rr_arbiter.sv
// Round-robin one-hot arbiter.
// ptr_i is the first channel searched this cycle.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NREQ) j = j - NREQ;
      if (gnt_o == '0 && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cov_arb.sv
// Multi-channel front end sharing one external 8-tap
// convolution datapath; tags results with their channel.
module cov_arb
  import cov_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIN_W-1:0] win,
  output logic [NREQ-1:0]       gnt,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_ch,
  input  logic [2:0]            cfg_tap,
  input  logic [COEF_W-1:0]     cfg_data,
  output logic                  cfg_err,
  output logic [WIN_W-1:0]      mac_din,
  output logic [K_W-1:0]        mac_k,
  output logic                  mac_valid,
  input  logic [RES_W-1:0]      mac_dout,
  output logic                  res_valid,
  output logic [1:0]            res_id,
  output logic [RES_W-1:0]      res_data,
  output logic                  busy,
  output logic                  drain_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 2);

  state_e            state_q;
  logic [IW-1:0]     ptr_q;
  logic [IW-1:0]     ptr_d;
  logic [IW-1:0]     gidx;
  logic              gany;
  logic              cfg_ok;
  logic [K_W-1:0]    k_sel;
  logic [COEF_W-1:0] coef_q [NREQ][TAPS];
  logic [WIN_W-1:0]  din_q;
  logic [K_W-1:0]    k_q;
  logic              mv_q;
  logic [IW-1:0]     mch_q;
  logic              tv_q [LAT];
  logic [IW-1:0]     tc_q [LAT];
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic              cerr_q;
  logic              dd_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i (req & {NREQ{state_q == S_RUN}}),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign gany   = |gnt;
  assign ptr_d  = (int'(gidx) == NREQ - 1) ? '0 : gidx + IW'(1);
  assign cfg_ok = cfg_we && (state_q == S_IDLE)
                  && (int'(cfg_ch) < NREQ);

  always_comb begin
    k_sel = '0;
    for (int t = 0; t < TAPS; t++)
      k_sel[t*COEF_W +: COEF_W] = coef_q[gidx][t];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (gany && !res_valid)
      cnt_d = cnt_q + CW'(1);
    else if (!gany && res_valid)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREQ; n++)
        for (int t = 0; t < TAPS; t++)
          coef_q[n][t] <= '0;
    end else if (cfg_ok) begin
      coef_q[IW'(cfg_ch)][cfg_tap] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      din_q   <= '0;
      k_q     <= '0;
      mv_q    <= 1'b0;
      mch_q   <= '0;
      cnt_q   <= '0;
      cerr_q  <= 1'b0;
      dd_q    <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        tv_q[k] <= 1'b0;
        tc_q[k] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      cerr_q <= cfg_we && !cfg_ok;
      dd_q   <= 1'b0;
      mv_q   <= gany;
      if (gany) begin
        ptr_q <= ptr_d;
        din_q <= win[int'(gidx)*WIN_W +: WIN_W];
        k_q   <= k_sel;
        mch_q <= gidx;
      end
      // tags trail the operand register so they meet mac_dout
      tv_q[0] <= mv_q;
      tc_q[0] <= mch_q;
      for (int k = 1; k < LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        tc_q[k] <= tc_q[k-1];
      end
      unique case (state_q)
        S_IDLE:  if (start) state_q <= S_RUN;
        S_RUN:   if (flush) state_q <= S_DRAIN;
        S_DRAIN: if (cnt_q == '0) begin
          state_q <= S_IDLE;
          dd_q    <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mac_din    = din_q;
  assign mac_k      = k_q;
  assign mac_valid  = mv_q;
  assign res_valid  = tv_q[LAT-1];
  assign res_id     = 2'(tc_q[LAT-1]);
  assign res_data   = mac_dout;
  assign cfg_err    = cerr_q;
  assign busy       = (state_q != S_IDLE);
  assign drain_done = dd_q;

endmodule

// File: tb/tb_cov_arb.sv
// Bench for cov_arb: external datapath model plus a
// queue-based reference of grants and tagged results.
module tb_cov_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic         clk = 1'b0;
  logic         rst, start, flush, cfg_we;
  logic [3:0]   req, gnt;
  logic [319:0] win;
  logic [1:0]   cfg_ch;
  logic [2:0]   cfg_tap;
  logic [7:0]   cfg_data;
  logic         cfg_err;
  logic [79:0]  mac_din;
  logic [63:0]  mac_k;
  logic         mac_valid;
  logic [20:0]  mac_dout;
  logic         res_valid;
  logic [1:0]   res_id;
  logic [20:0]  res_data;
  logic         busy, drain_done;

  cov_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .req(req), .win(win), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_tap(cfg_tap),
    .cfg_data(cfg_data), .cfg_err(cfg_err),
    .mac_din(mac_din), .mac_k(mac_k), .mac_valid(mac_valid),
    .mac_dout(mac_dout), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .busy(busy), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [20:0] dp_conv(input logic [79:0] d,
                                          input logic [63:0] k);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++)
      s += int'(d[i*10 +: 10]) * int'(k[i*8 +: 8]);
    return 21'(s);
  endfunction

  // external datapath: LAT-cycle pipelined dot product
  logic [20:0] dp [LAT];
  always @(posedge clk) begin
    dp[0] <= dp_conv(mac_din, mac_k);
    for (int k = 1; k < LAT; k++) dp[k] <= dp[k-1];
  end
  assign mac_dout = dp[LAT-1];

  typedef struct {
    int          id;
    logic [20:0] data;
    int          due;
  } exp_t;

  int         n_chk = 0;
  int         n_pass = 0;
  int         m_ptr;
  logic [7:0] m_coef [4][8];
  exp_t       q[$];

  function automatic logic [20:0] mdl_conv(input logic [79:0] d,
                                           input int ch);
    int s;
    s = 0;
    for (int i = 0; i < 8; i++)
      s += int'(d[i*10 +: 10]) * int'(m_coef[ch][i]);
    return 21'(s);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; req = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_tap = '0; cfg_data = '0;
    tick; tick;
    rst = 1'b0;
    m_ptr = 0;
    q.delete();
    for (int c = 0; c < 4; c++)
      for (int t = 0; t < 8; t++) m_coef[c][t] = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'hF;
    win = 320'({$urandom(), $urandom(), $urandom(), $urandom()});
    tick; tick;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_chk++; if (mac_valid !== 1'b0) $display("FAIL rst_mac_valid got %b exp 0", mac_valid); else n_pass++;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid got %b exp 0", res_valid); else n_pass++;
    n_chk++; if (cfg_err !== 1'b0) $display("FAIL rst_cfg_err got %b exp 0", cfg_err); else n_pass++;
    n_chk++; if (drain_done !== 1'b0) $display("FAIL rst_drain_done got %b exp 0", drain_done); else n_pass++;
    n_chk++; if (mac_din !== '0) $display("FAIL rst_mac_din got %h exp 0", mac_din); else n_pass++;
    n_chk++; if (mac_k !== '0) $display("FAIL rst_mac_k got %h exp 0", mac_k); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (gnt !== 4'b0) $display("FAIL idle_gnt got %b exp 0000", gnt); else n_pass++;
    req = '0;
  endtask

  task automatic test_single;
    logic [319:0] w;
    do_reset;
    for (int t = 0; t < 8; t++) begin
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_tap = 3'(t); cfg_data = 8'(t + 1);
      tick;
      cfg_we = 1'b0;
      n_chk++; if (cfg_err !== 1'b0) $display("FAIL idle_cfg_err got %b exp 0", cfg_err); else n_pass++;
    end
    for (int i = 0; i < 32; i++) w[i*10 +: 10] = 10'd10;
    win = w;
    start = 1'b1; tick; start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL start_busy got %b exp 1", busy); else n_pass++;
    req = 4'b0010; #1;
    n_chk++; if (gnt !== 4'b0010) $display("FAIL single_gnt got %b exp 0010", gnt); else n_pass++;
    tick; req = '0;
    n_chk++; if (mac_valid !== 1'b1) $display("FAIL single_mac_valid got %b exp 1", mac_valid); else n_pass++;
    n_chk++; if (mac_k !== 64'h0807060504030201) $display("FAIL single_mac_k got %h exp 0807060504030201", mac_k); else n_pass++;
    n_chk++; if (mac_din !== w[80 +: 80]) $display("FAIL single_mac_din got %h exp %h", mac_din, w[80 +: 80]); else n_pass++;
    #1;
    n_chk++; if (gnt !== 4'b0) $display("FAIL single_gnt_drop got %b exp 0000", gnt); else n_pass++;
    for (int k = 2; k <= LAT + 1; k++) begin
      tick;
      if (k <= LAT) begin
        n_chk++; if (res_valid !== 1'b0) $display("FAIL single_early k=%0d got %b exp 0", k, res_valid); else n_pass++;
      end else begin
        n_chk++; if (res_valid !== 1'b1) $display("FAIL single_res_valid got %b exp 1", res_valid); else n_pass++;
        n_chk++; if (res_id !== 2'd1) $display("FAIL single_res_id got %0d exp 1", res_id); else n_pass++;
        n_chk++; if (res_data !== 21'd360) $display("FAIL single_res_data got %0d exp 360", res_data); else n_pass++;
      end
    end
    tick;
    n_chk++; if (res_valid !== 1'b0) $display("FAIL single_res_once got %b exp 0", res_valid); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int idx;
    logic [3:0] e;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 8 + LAT + 2; c++) begin
      idx = c - 1 - LAT;
      if (idx >= 0 && idx < 8) begin
        n_chk++; if (res_valid !== 1'b1 || res_id !== 2'(idx % 4)) $display("FAIL b2b_res c=%0d got %b/%0d exp 1/%0d", c, res_valid, res_id, idx % 4); else n_pass++;
      end else begin
        n_chk++; if (res_valid !== 1'b0) $display("FAIL b2b_res_idle c=%0d got %b exp 0", c, res_valid); else n_pass++;
      end
      if (c >= 1 && c <= 8) begin
        n_chk++; if (mac_valid !== 1'b1) $display("FAIL b2b_gap c=%0d got %b exp 1", c, mac_valid); else n_pass++;
      end
      req = (c < 8) ? 4'hF : 4'h0;
      e = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
      #1;
      n_chk++; if (gnt !== e) $display("FAIL b2b_gnt c=%0d got %b exp %b", c, gnt, e); else n_pass++;
      tick;
    end
  endtask

  task automatic test_cfg_run;
    do_reset;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_tap = 3'd3; cfg_data = 8'h55;
    tick; cfg_we = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_tap = 3'd3; cfg_data = 8'hAA;
    tick; cfg_we = 1'b0;
    n_chk++; if (cfg_err !== 1'b1) $display("FAIL run_cfg_err got %b exp 1", cfg_err); else n_pass++;
    tick;
    n_chk++; if (cfg_err !== 1'b0) $display("FAIL run_cfg_err_pulse got %b exp 0", cfg_err); else n_pass++;
    req = 4'b0100; #1;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL run_cfg_gnt got %b exp 0100", gnt); else n_pass++;
    tick; req = '0;
    n_chk++; if (mac_k[31:24] !== 8'h55) $display("FAIL run_cfg_table got %h exp 55", mac_k[31:24]); else n_pass++;
  endtask

  task automatic test_flush_drain;
    int  nres, last, dc;
    logic done;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    req = 4'hF; tick; tick; tick;
    req = '0; flush = 1'b1; tick; flush = 1'b0;
    nres = 0; last = -1; dc = -1; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (res_valid === 1'b1) begin nres++; last = c; end
      if (drain_done === 1'b1) begin
        done = 1'b1; dc = c;
        n_chk++; if (busy !== 1'b0) $display("FAIL drain_busy got %b exp 0", busy); else n_pass++;
      end else begin
        req = 4'hF; #1;
        n_chk++; if (gnt !== 4'b0) $display("FAIL drain_gnt c=%0d got %b exp 0000", c, gnt); else n_pass++;
        tick;
      end
    end
    req = '0;
    n_chk++; if (!done) $display("FAIL drain_timeout got 0 exp 1"); else n_pass++;
    n_chk++; if (nres != 3) $display("FAIL drain_nres got %0d exp 3", nres); else n_pass++;
    n_chk++; if (dc <= last) $display("FAIL drain_order got done=%0d last_res=%0d exp done later", dc, last); else n_pass++;
    tick;
    n_chk++; if (busy !== 1'b0 || drain_done !== 1'b0) $display("FAIL drain_after got %b/%b exp 0/0", busy, drain_done); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic seen, done;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    req = 4'hF; tick; tick;
    req = '0; rst = 1'b1; tick; rst = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy); else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      if (res_valid !== 1'b0) seen = 1'b1;
      tick;
    end
    n_chk++; if (seen) $display("FAIL mid_res got 1 exp 0"); else n_pass++;
    start = 1'b1; tick; start = 1'b0;
    flush = 1'b1; tick; flush = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 5 && !done; c++) begin
      if (drain_done === 1'b1) done = 1'b1;
      else tick;
    end
    n_chk++; if (!done) $display("FAIL mid_count got stuck exp drain_done"); else n_pass++;
  endtask

  task automatic test_ignore;
    int  nres;
    logic done;
    do_reset;
    flush = 1'b1; tick; flush = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL ign_flush got %b exp 0", busy); else n_pass++;
    start = 1'b1; tick; start = 1'b0;
    n_chk++; if (busy !== 1'b1) $display("FAIL ign_start got %b exp 1", busy); else n_pass++;
    req = 4'b0100; flush = 1'b1; #1;
    n_chk++; if (gnt !== 4'b0100) $display("FAIL ign_gnt got %b exp 0100", gnt); else n_pass++;
    tick; flush = 1'b0; start = 1'b1; #1;
    n_chk++; if (busy !== 1'b1 || gnt !== 4'b0) $display("FAIL ign_drain got %b/%b exp 1/0000", busy, gnt); else n_pass++;
    tick; start = 1'b0;
    nres = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (res_valid === 1'b1) begin
        nres++;
        n_chk++; if (res_id !== 2'd2) $display("FAIL ign_res_id got %0d exp 2", res_id); else n_pass++;
      end
      if (drain_done === 1'b1) done = 1'b1;
      else tick;
    end
    req = '0;
    n_chk++; if (!done || nres != 1) $display("FAIL ign_deliver got done=%b n=%0d exp 1/1", done, nres); else n_pass++;
    tick;
    n_chk++; if (busy !== 1'b0) $display("FAIL ign_idle got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_random;
    logic [3:0]   pend, eg;
    logic [319:0] w;
    logic         pwe, erv, done;
    int           j, gch;
    exp_t         e;
    do_reset;
    for (int c = 0; c < 4; c++)
      for (int t = 0; t < 8; t++) begin
        m_coef[c][t] = 8'($urandom);
        cfg_we = 1'b1; cfg_ch = 2'(c); cfg_tap = 3'(t);
        cfg_data = m_coef[c][t];
        tick;
      end
    cfg_we = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    pend = '0; w = '0; pwe = 1'b0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      erv = (q.size() > 0 && q[0].due == cyc);
      n_chk++; if (res_valid !== erv) $display("FAIL rnd_res_valid c=%0d got %b exp %b", c, res_valid, erv); else n_pass++;
      if (erv) begin
        e = q.pop_front();
        n_chk++; if (res_id !== 2'(e.id) || res_data !== e.data) $display("FAIL rnd_res got %0d/%0d exp %0d/%0d", res_id, res_data, e.id, e.data); else n_pass++;
      end
      n_chk++; if (cfg_err !== pwe) $display("FAIL rnd_cfg_err c=%0d got %b exp %b", c, cfg_err, pwe); else n_pass++;
      if (drain_done === 1'b1) begin
        done = 1'b1;
      end else begin
        if (c < 300) begin
          for (int ch = 0; ch < 4; ch++)
            if (!pend[ch] && $urandom_range(1, 0) == 1) begin
              pend[ch] = 1'b1;
              w[ch*80 +: 80] = 80'({$urandom(), $urandom(), $urandom()});
            end
          req = pend; win = w;
          cfg_we = ($urandom_range(7, 0) == 0);
          cfg_ch = 2'($urandom); cfg_tap = 3'($urandom);
          cfg_data = 8'($urandom);
        end else begin
          req = '0; cfg_we = 1'b0;
        end
        flush = (c == 300);
        pwe = cfg_we;
        #1;
        eg = '0; gch = 0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr + k) % 4;
          if (eg == '0 && req[j]) begin eg[j] = 1'b1; gch = j; end
        end
        n_chk++; if (gnt !== eg) $display("FAIL rnd_gnt c=%0d got %b exp %b", c, gnt, eg); else n_pass++;
        if (eg != '0) begin
          q.push_back('{gch, mdl_conv(w[gch*80 +: 80], gch), cyc + 1 + LAT});
          pend[gch] = 1'b0;
          m_ptr = (gch + 1) % 4;
        end
        tick;
      end
    end
    flush = 1'b0; cfg_we = 1'b0; req = '0;
    n_chk++; if (!done || q.size() != 0) $display("FAIL rnd_drain got done=%b left=%0d exp 1/0", done, q.size()); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; req = '0; win = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_tap = '0; cfg_data = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_cfg_run;
    test_flush_drain;
    test_reset_mid;
    test_ignore;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cov_arb.md
COV_ARB -- requirements
Module: cov_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requester channels sharing one 8-tap convolution datapath.
REQ-002 Parameter LAT, default 3: convolution datapath latency in clocks from sampled operands to valid result.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; IDLE -> RUN.
REQ-006 flush  input  1  one-cycle pulse; RUN -> DRAIN.
REQ-007 req  input  NREQ  per-channel request; held high until granted.
REQ-008 win  input  NREQ*80  per-channel window, 8 x 10-bit unsigned pixels; tap0 = bits [9:0].
REQ-009 gnt  output  NREQ  one-hot grant; the window is consumed in the grant cycle.
REQ-010 cfg_we  input  1  kernel coefficient write strobe.
REQ-011 cfg_ch  input  2  channel index of the write.
REQ-012 cfg_tap  input  3  tap index of the write.
REQ-013 cfg_data  input  8  unsigned coefficient.
REQ-014 cfg_err  output  1  one-cycle pulse; write rejected.
REQ-015 mac_din  output  80  operands to datapath din1..din8.
REQ-016 mac_k  output  64  coefficients to datapath k1..k8.
REQ-017 mac_valid  output  1  operands valid this cycle.
REQ-018 mac_dout  input  21  datapath result.
REQ-019 res_valid  output  1  result valid.
REQ-020 res_id  output  2  channel owning the result.
REQ-021 res_data  output  21  result, copy of mac_dout.
REQ-022 busy  output  1  high when state is not IDLE.
REQ-023 drain_done  output  1  one-cycle pulse on DRAIN -> IDLE.

Function
REQ-024 FSM states: IDLE, RUN, DRAIN.
REQ-025 IDLE -> RUN on start; start in RUN or DRAIN is ignored.
REQ-026 RUN -> DRAIN on flush; flush in IDLE or DRAIN is ignored.
REQ-027 DRAIN -> IDLE once the in-flight count is zero; drain_done pulses in the cycle IDLE is entered.
REQ-028 Grants occur only in RUN, at most one per cycle; gnt is combinational from req, the state and the priority pointer.
REQ-029 Arbitration is round-robin: search starts at the channel after the last one granted; after reset the search starts at channel 0.
REQ-030 A flush and a req in the same cycle are handled with the grant issued that cycle and DRAIN entered next cycle.
REQ-031 Grant in cycle t drives mac_din, mac_k and mac_valid = 1 registered at t+1; mac_valid = 0 otherwise.
REQ-032 mac_k carries the granted channel's 8 stored coefficients.
REQ-033 Tag pipeline of depth LAT carries {valid, channel}: res_valid/res_id at t+1+LAT, with res_data = mac_dout in that same cycle.
REQ-034 In-flight counter, width clog2(LAT+2):
- +1 on grant, -1 on res_valid, unchanged when both occur.
- Never exceeds LAT+1.
REQ-035 Coefficient table is NREQ x 8 x 8-bit.
REQ-036 A cfg write is accepted only in IDLE and is visible from the next cycle.
REQ-037 A cfg write in RUN or DRAIN is discarded; cfg_err pulses in the following cycle.
REQ-038 A cfg write with cfg_ch >= NREQ is discarded and raises cfg_err.
REQ-039 No arithmetic on data; widths pass through unchanged.

Reset
REQ-040 On rst:
- state = IDLE; priority pointer = 0; tag pipeline cleared; in-flight count = 0.
- mac_valid, res_valid, cfg_err, drain_done = 0; mac_din, mac_k = 0.
REQ-041 Coefficient table resets to all zeros.
REQ-042 Reset mid-operation discards in-flight results; no res_valid is produced for them.

Structure
REQ-043 Shared package holds:
- FSM state encoding;
- constants PIX_W = 10, COEF_W = 8, TAPS = 8, RES_W = 21.
REQ-044 One sub-module, rr_arbiter (req, last-grant pointer -> one-hot gnt), is instantiated once.
REQ-045 Datapath is external; this block only connects to it.

Verification
REQ-046 Write ch1 taps 0..7 = 1..8 in IDLE, start, then req[1] with all pixels = 10 -> gnt[1] for 1 cycle; res_valid with res_id = 1 exactly LAT+1 cycles later (bench model returns 360).
REQ-047 req = 4'b1111 held in RUN for 8 cycles -> grant order 0,1,2,3,0,1,2,3; no gaps; res_id sequence identical.
REQ-048 cfg write during RUN -> table unchanged; cfg_err = 1 in the next cycle only.
REQ-049 flush with 3 results in flight -> no further grants; drain_done after the last res_valid; busy = 0 next cycle.
REQ-050 rst asserted while 2 results are in flight -> no res_valid afterwards; state IDLE; counter 0.
REQ-051 start and flush in IDLE, then flush in the same cycle as req[2] in RUN -> IDLE ignores flush; gnt[2] issued; DRAIN entered; one result delivered.
